// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a TXDATA/STATUS register window feeding a
// byte FIFO that a four-state serialiser drains onto the tx pin.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memWrite,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        txBusy,
    output logic        overflow
);

    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] LAST_C  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg, count_next;
    logic          overflow_reg, overflow_next;

    state_t        state_reg, state_next;
    logic [15:0]   cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg, tx_next;

    logic          push_req, push_ok, clr_req, pop, bit_end;
    logic          empty, full;
    logic [7:0]    count8;
    logic          unused_bits;

    assign sel      = (addr[31:3] == BASE_ADDR[31:3]);
    assign push_req = memWrite & sel & ~addr[2];
    assign clr_req  = memWrite & sel & addr[2] & wdata[3];
    // A full FIFO still takes a byte when the serialiser frees a slot on the same edge.
    assign push_ok  = push_req & ((count_reg != DEPTH_C) | pop);

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == DEPTH_C);
    assign count8   = 8'(count_reg);
    assign txBusy   = (state_reg != IDLE) | ~empty;
    assign overflow = overflow_reg;
    assign tx       = tx_reg;
    assign rdata    = (sel & addr[2]) ? {20'b0, count8, overflow_reg, txBusy, empty, full} : 32'b0;

    assign unused_bits = &{1'b0, addr[1:0], wdata[31:8]};

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + (PW + 1)'(1);
            2'b01:   count_next = count_reg - (PW + 1)'(1);
            default: count_next = count_reg;
        endcase
        overflow_next = overflow_reg;
        if (push_req & ~push_ok)
            overflow_next = 1'b1;
        else if (clr_req)
            overflow_next = 1'b0;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        pop        = 1'b0;
        bit_end    = (cnt_reg == LAST_C);
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr_reg];
                    state_next = START;
                    cnt_next   = '0;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                    cnt_next   = '0;
                    tx_next    = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    shift_next = shift_reg >> 1;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        tx_next  = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    // Chain straight into the next start bit so queued frames abut.
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr_reg];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed register-window stimulus, with a UART-receiver
// monitor that decodes the tx line and checks each frame against a byte queue.
module tb_mmio_uart_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        memWrite = 1'b0;
    logic        sel, tx, txBusy, overflow;
    logic [31:0] rdata;

    mmio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .BASE_ADDR(32'h0000_0400)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .memWrite(memWrite),
        .sel(sel), .rdata(rdata), .tx(tx), .txBusy(txBusy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    int         e0 = 0;
    int         lows = 0;
    logic [9:0] pat = 10'b1101001010;

    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_rx = 8'h0;
    logic [7:0] mon_exp = 8'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; memWrite = 1'b1;
        @(posedge clk);
        #1 memWrite = 1'b0;
        $display("[TB] store addr=%h data=%h cyc=%0d", a, d, cyc);
    endtask

    task automatic status_is(input string name, input logic [31:0] exp);
        addr = 32'h404; memWrite = 1'b0;
        #1;
        $display("[TB] load status=%h cyc=%0d", rdata, cyc);
        check(name, rdata, exp);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (txBusy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", {31'b0, txBusy}, 32'h0);
    endtask

    // Receiver: samples mid-bit on the falling edge, aborts any frame under reset.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    starts.push_back(cyc);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == C / 2)
                    check("start_bit", {31'b0, tx}, 32'h0);
                else if (mon_cnt > C / 2 && mon_cnt < 9 * C && (mon_cnt % C) == C / 2)
                    mon_rx[mon_cnt / C - 1] = tx;
                else if (mon_cnt == 9 * C + C / 2) begin
                    check("stop_bit", {31'b0, tx}, 32'h1);
                    $display("[TB] frame rx=%h cyc=%0d", mon_rx, cyc);
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL unexpected_frame: got %h expected none", mon_rx);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        n_tests--;
                        check("rx_byte", {24'b0, mon_rx}, {24'b0, mon_exp});
                    end
                end
                if (mon_cnt == 10 * C - 1)
                    mon_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset state
        @(posedge clk); #1;
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_busy", {31'b0, txBusy}, 32'h0);
        check("rst_ovf", {31'b0, overflow}, 32'h0);
        status_is("rst_status", 32'h002);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single byte: latency, line pattern, frame length
        exp_q.push_back(8'hA5);
        store(32'h400, 32'h0000_00A5);
        check("t1_tx_edgeE", {31'b0, tx}, 32'h1);
        @(posedge clk); #1;
        for (int b = 0; b < 10; b++) begin
            check($sformatf("t1_line_b%0d", b), {31'b0, tx}, {31'b0, pat[b]});
            if (b == 9)
                check("t1_busy_stop", {31'b0, txBusy}, 32'h1);
            repeat (C) @(posedge clk);
            #1;
        end
        check("t1_busy_end", {31'b0, txBusy}, 32'h0);
        status_is("t1_status", 32'h002);

        // Burst fill, overflow, sticky clear, push on full while popping
        starts.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(8'h11 + i));
            store(32'h400, 32'(8'h11 + i));
            if (i == 0) e0 = cyc;
        end
        check("t2_ovf0", {31'b0, overflow}, 32'h0);
        status_is("t2_full", 32'h045);
        store(32'h400, 32'h16);
        check("t2_ovf1", {31'b0, overflow}, 32'h1);
        status_is("t2_status_ovf", 32'h04D);
        store(32'h404, 32'h4);
        check("t3_noclr", {31'b0, overflow}, 32'h1);
        status_is("t3_status_noclr", 32'h04D);
        store(32'h404, 32'h8);
        check("t3_clr", {31'b0, overflow}, 32'h0);
        status_is("t3_status_clr", 32'h045);
        exp_q.push_back(8'h17);
        while (cyc < e0 + 40) begin
            @(posedge clk); #1;
        end
        store(32'h400, 32'h17);
        check("t4_ovf", {31'b0, overflow}, 32'h0);
        status_is("t4_status", 32'h045);
        wait_idle(400);
        status_is("t4_status_idle", 32'h002);
        check("t4_queue_empty", 32'(exp_q.size()), 32'h0);
        check("t4_frames", 32'(starts.size()), 32'd6);
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("t4_gap%0d", i), 32'(starts[i] - starts[i-1]), 32'd40);

        // Reset in the middle of a data bit with bytes still queued
        store(32'h400, 32'h5A);
        e0 = cyc;
        store(32'h400, 32'h33);
        store(32'h400, 32'h44);
        status_is("t5_status_q", 32'h024);
        while (cyc < e0 + 14) begin
            @(posedge clk); #1;
        end
        check("t5_bit2", {31'b0, tx}, 32'h0);
        while (cyc < e0 + 18) begin
            @(posedge clk); #1;
        end
        check("t5_bit3", {31'b0, tx}, 32'h1);
        reset = 1'b0;
        #1;
        $display("[TB] reset asserted cyc=%0d", cyc);
        check("t5_rst_tx", {31'b0, tx}, 32'h1);
        check("t5_rst_busy", {31'b0, txBusy}, 32'h0);
        status_is("t5_rst_status", 32'h002);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("t5_silent", 32'(lows), 32'h0);
        @(posedge clk); #1;
        status_is("t5_status_after", 32'h002);

        // Status with traffic, address decode, out-of-window stores
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(8'h61 + i));
            store(32'h400, 32'(8'h61 + i));
        end
        status_is("t6_status", 32'h034);
        addr = 32'h400; #1;
        check("t6_sel_400", {31'b0, sel}, 32'h1);
        check("t6_rdata_400", rdata, 32'h0);
        addr = 32'h404; #1;
        check("t6_sel_404", {31'b0, sel}, 32'h1);
        addr = 32'h3FC; #1;
        check("t6_sel_3fc", {31'b0, sel}, 32'h0);
        check("t6_rdata_3fc", rdata, 32'h0);
        addr = 32'h408; #1;
        check("t6_sel_408", {31'b0, sel}, 32'h0);
        store(32'h3FC, 32'h77);
        store(32'h408, 32'h78);
        status_is("t6_status_after", 32'h034);
        wait_idle(400);
        status_is("t6_status_idle", 32'h002);
        check("t6_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
